// File: rtl/if_fetch_unit_pkg.sv
// Shared configuration for the instruction-fetch front end: reset vector,
// queue geometry, queue entry layout and small PC helper functions.
package if_fetch_unit_pkg;

   localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
   localparam int          QDEPTH     = 2;
   localparam logic [1:0]  QCOUNT_MAX = 2'd2;
   localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

   // One queued fetch: the address it came from and the word returned.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0000_0000, instr: NOP_WORD};

   // Sequential fetch address; wraps naturally at the top of the 32-bit space.
   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   // Redirect targets are forced onto a word boundary.
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bus between the fetch unit and the instruction cache data port.
// The fetch side supplies the address and a freeze request; the cache
// returns the word for that address and a miss indication.
interface if_fetch_unit_if;
   import if_fetch_unit_pkg::*;

   logic [31:0] ic_addr;
   logic        ic_stall;
   logic [31:0] ic_data;
   logic        ic_stop;

   modport master (
      output ic_addr,
      output ic_stall,
      input  ic_data,
      input  ic_stop
   );

   modport slave (
      input  ic_addr,
      input  ic_stall,
      output ic_data,
      output ic_stop
   );

endinterface

// File: rtl/if_fetch_unit_queue.sv
// Two-entry instruction queue between the cache and decode.
// Flush wins over push/pop. A push while full is accepted only when the
// head is popped in the same cycle (full-through); the new word then lands
// in the slot being vacated.
module if_fetch_unit_queue
   import if_fetch_unit_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t wdata_i,
   output fetch_entry_t head_o,
   output logic         full_o,
   output logic         empty_o
);

   fetch_entry_t entry_q [QDEPTH];
   fetch_entry_t entry_d [QDEPTH];
   logic         head_q, head_d;
   logic [1:0]   count_q, count_d;
   logic         tail_s;
   logic         do_pop_s;
   logic         do_push_s;

   assign full_o    = (count_q == QCOUNT_MAX);
   assign empty_o   = (count_q == 2'd0);
   // With two slots the tail is the head when empty or full, the other slot otherwise.
   assign tail_s    = head_q ^ count_q[0];
   assign do_pop_s  = pop_i & ~empty_o;
   assign do_push_s = push_i & (~full_o | do_pop_s);
   assign head_o    = entry_q[head_q];

   // Next-state for storage, head pointer and occupancy.
   always_comb begin
      entry_d = entry_q;
      head_d  = head_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = 1'b0;
         count_d = 2'd0;
      end else begin
         if (do_push_s) begin
            entry_d[tail_s] = wdata_i;
         end else begin
            entry_d = entry_q;
         end
         if (do_pop_s) begin
            head_d = ~head_q;
         end else begin
            head_d = head_q;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // Queue state registers; reset clears every slot so nothing stale can appear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < QDEPTH; i++) begin
            entry_q[i] <= EMPTY_ENTRY;
         end
         head_q  <= 1'b0;
         count_q <= 2'd0;
      end else begin
         entry_q <= entry_d;
         head_q  <= head_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end. Owns the PC, drives the cache address,
// captures returned words into a two-entry queue and presents the queue
// head to decode. Cache misses, decode backpressure and redirects are
// absorbed here so the cache and decode never see each other's timing.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC_P = RESET_PC
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   if_fetch_unit_if.master       ic,
   output logic                  instr_valid,
   output logic [31:0]           instr,
   output logic [31:0]           instr_pc
);

   logic [31:0]  pc_q, pc_d;
   logic         pop_s;
   logic         push_s;
   logic         full_s;
   logic         empty_s;
   fetch_entry_t head_s;
   fetch_entry_t wdata_s;

   // Decode takes the head whenever one is shown and it is not stalling.
   assign pop_s   = ~empty_s & ~stall;
   // A returned word is kept only if there is room (or room is being made)
   // and no redirect is discarding the current fetch stream.
   assign push_s  = ~ic.ic_stop & (~full_s | pop_s) & ~redirect_valid;
   assign wdata_s = '{pc: pc_q, instr: ic.ic_data};

   if_fetch_unit_queue u_queue (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .flush_i (redirect_valid),
      .wdata_i (wdata_s),
      .head_o  (head_s),
      .full_o  (full_s),
      .empty_o (empty_s)
   );

   // PC advances only when the word at pc was captured; redirect overrides.
   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) begin
         pc_d = align_pc(redirect_pc);
      end else if (push_s) begin
         pc_d = next_pc(pc_q);
      end else begin
         pc_d = pc_q;
      end
   end

   // PC register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q <= RESET_PC_P;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign ic.ic_addr  = pc_q;
   // Freeze the cache only when the queue is full and nothing leaves it.
   assign ic.ic_stall = full_s & ~pop_s;
   assign instr_valid = ~empty_s;
   assign instr       = head_s.instr;
   assign instr_pc    = head_s.pc;

endmodule
